// File: rtl/timer_request_arbiter.sv
// Round-robin arbiter that lends one 1 Hz countdown to NUM_REQ requesters.
// The owner's duration is counted down in whole seconds and the owner gets
// a one-cycle done pulse on expiry. The owner can abort by dropping its request.
module timer_request_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DUR_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     secPulse,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DUR_W-1:0] dur,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [DUR_W-1:0]         remaining
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [PtrW-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [DUR_W-1:0]   rem_q, rem_d;

    logic               pick_valid;
    logic [PtrW-1:0]    pick_idx;
    logic [DUR_W-1:0]   pick_dur;
    logic [PtrW-1:0]    owner_next;

    // Round-robin search: first active request at or after ptr, wrapping.
    always_comb begin
        int unsigned     idx;
        logic [PtrW-1:0] idx_p;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        idx_p      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx   = (32'(ptr_q) + k) % NUM_REQ;
            idx_p = PtrW'(idx);
            if (!pick_valid && req[idx_p]) begin
                pick_valid = 1'b1;
                pick_idx   = idx_p;
            end
        end
    end

    // Duration of the winning requester and the slot after the current owner.
    always_comb begin
        pick_dur   = dur[pick_idx*DUR_W +: DUR_W];
        owner_next = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + PtrW'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        rem_d   = rem_q;

        unique case (state_q)
            StIdle: begin
                // secPulse is ignored here, so a tick on the grant-load edge never counts.
                if (pick_valid) begin
                    owner_d = pick_idx;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    busy_d  = 1'b1;
                    rem_d   = pick_dur;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (rem_q == '0) begin
                    // Zero-length grant: expires on its first cycle, no tick needed.
                    done_d  = grant_q;
                    state_d = StDone;
                end else if (!req[owner_q]) begin
                    // Abort beats a coincident final tick.
                    grant_d = '0;
                    busy_d  = 1'b0;
                    rem_d   = '0;
                    ptr_d   = owner_next;
                    state_d = StIdle;
                end else if (secPulse) begin
                    rem_d = rem_q - DUR_W'(1);
                    if (rem_q == DUR_W'(1)) begin
                        done_d  = grant_q;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                grant_d = '0;
                busy_d  = 1'b0;
                rem_d   = '0;
                ptr_d   = owner_next;
                state_d = StIdle;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                rem_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rem_q   <= rem_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign remaining = rem_q;

endmodule
